// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch / IF-ID pipeline slice.
package pipe_pkg;

    // Architectural word used for PCs and instructions.
    typedef logic [31:0] word_t;

    // Bubble inserted into IF/ID on a flush.
    localparam word_t NOP_INSTR = 32'h0000_0000;

    // Byte distance between sequential instructions.
    localparam word_t INSTR_BYTES = 32'd4;

    // Fetch FSM encodings; the numeric values are visible on fetch_state_o.
    typedef enum logic [1:0] {
        FS_RUN      = 2'd0,
        FS_STALL    = 2'd1,
        FS_REDIRECT = 2'd2
    } fetch_state_t;

    // Sequential successor of a fetch address; wraps silently at the top of memory.
    function automatic word_t next_seq_pc(input word_t pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on rst.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    // Next count: advance only while below the all-ones ceiling.
    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/ifid_fetch_stage.sv
// Fetch stage plus IF/ID pipeline register. Owns the PC, captures the
// instruction word, inserts bubbles on flush, tracks run/stall/redirect,
// counts stall and flush cycles and flags stalls that run too long.
module ifid_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_STALL = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pcwrite_i,
    input  logic             ifid_write_i,
    input  logic             ifid_flush_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_target_i,
    input  logic [31:0]      imem_instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [1:0]       fetch_state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             stall_err_o
);

    // The consecutive-stall counter only needs to reach MAX_STALL+1, where it parks.
    localparam int unsigned CONSEC_W = $clog2(MAX_STALL + 2);
    localparam logic [CONSEC_W-1:0] CONSEC_LIMIT = CONSEC_W'(MAX_STALL);
    localparam logic [CONSEC_W-1:0] CONSEC_SAT   = CONSEC_W'(MAX_STALL + 1);

    // PC is always word aligned, including the reset value.
    localparam word_t RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    word_t        pc_reg,        pc_next;
    word_t        ifid_pc4_reg,  ifid_pc4_next;
    word_t        ifid_instr_reg, ifid_instr_next;
    logic         ifid_valid_reg, ifid_valid_next;
    fetch_state_t state_reg,     state_next;
    logic [CONSEC_W-1:0] consec_reg, consec_next;
    logic         err_reg,       err_next;

    word_t pc_plus4;
    word_t redirect_pc;
    logic  stall;

    // Low target bits are architecturally ignored.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target_i[1:0];

    assign pc_plus4    = next_seq_pc(pc_reg);
    assign redirect_pc = {branch_target_i[31:2], 2'b00};

    // A branch always moves the PC, so it never counts as a stall.
    assign stall = !pcwrite_i && !branch_i;

    // PC next value: branch redirect beats sequential advance beats hold.
    always_comb begin
        pc_next = pc_reg;
        if (branch_i) begin
            pc_next = redirect_pc;
        end else if (pcwrite_i) begin
            pc_next = pc_plus4;
        end
    end

    // PC register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_reg <= RESET_PC_ALIGNED;
        end else begin
            pc_reg <= pc_next;
        end
    end

    // IF/ID next value: flush bubble beats load beats hold.
    always_comb begin
        ifid_instr_next = ifid_instr_reg;
        ifid_pc4_next   = ifid_pc4_reg;
        ifid_valid_next = ifid_valid_reg;
        if (ifid_flush_i) begin
            ifid_instr_next = NOP_INSTR;
            ifid_pc4_next   = '0;
            ifid_valid_next = 1'b0;
        end else if (ifid_write_i) begin
            ifid_instr_next = imem_instr_i;
            ifid_pc4_next   = pc_plus4;
            ifid_valid_next = 1'b1;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ifid_instr_reg <= NOP_INSTR;
            ifid_pc4_reg   <= '0;
            ifid_valid_reg <= 1'b0;
        end else begin
            ifid_instr_reg <= ifid_instr_next;
            ifid_pc4_reg   <= ifid_pc4_next;
            ifid_valid_reg <= ifid_valid_next;
        end
    end

    // Fetch FSM next state: redirect wins, then stall, otherwise run.
    always_comb begin
        state_next = FS_RUN;
        if (branch_i) begin
            state_next = FS_REDIRECT;
        end else if (stall) begin
            state_next = FS_STALL;
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= FS_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Stall watchdog: count consecutive stalls, latch the error once the run would pass MAX_STALL.
    always_comb begin
        consec_next = '0;
        err_next    = err_reg;
        if (stall) begin
            consec_next = (consec_reg == CONSEC_SAT) ? consec_reg
                                                     : consec_reg + {{(CONSEC_W-1){1'b0}}, 1'b1};
            if (consec_reg >= CONSEC_LIMIT) begin
                err_next = 1'b1;
            end
        end
    end

    // Watchdog registers; the error is sticky until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            consec_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            consec_reg <= consec_next;
            err_reg    <= err_next;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (stall),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (ifid_flush_i),
        .count (flush_cnt_o)
    );

    assign pc_o          = pc_reg;
    assign ifid_pc4_o    = ifid_pc4_reg;
    assign ifid_instr_o  = ifid_instr_reg;
    assign ifid_valid_o  = ifid_valid_reg;
    assign fetch_state_o = state_reg;
    assign stall_err_o   = err_reg;

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Self-checking bench for ifid_fetch_stage: expected snapshots are queued
// when stimulus is driven and compared after the clock edge that consumes it.
module tb_ifid_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [1:0]  state;
        logic [15:0] scnt;
        logic [15:0] fcnt;
        logic        err;
    } snap_t;

    logic        clk;
    logic        rst;
    logic        pcwrite;
    logic        ifid_write;
    logic        ifid_flush;
    logic        branch;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [1:0]  fetch_state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        stall_err;

    // Narrow-counter instance for saturation.
    logic        s_flush;
    logic [31:0] s_pc;
    logic [31:0] s_ifid_pc4;
    logic [31:0] s_ifid_instr;
    logic        s_ifid_valid;
    logic [1:0]  s_fetch_state;
    logic [3:0]  s_stall_cnt;
    logic [3:0]  s_flush_cnt;
    logic        s_stall_err;

    int n_checks = 0;
    int n_errors = 0;

    snap_t sb_q[$];
    snap_t got, want;

    // Bench-side expectation of the DUT state.
    logic [31:0] e_pc, e_pc4, e_instr;
    logic        e_valid, e_err;
    logic [1:0]  e_state;
    logic [15:0] e_scnt, e_fcnt;

    ifid_fetch_stage #(.RESET_PC(32'h0), .CNT_W(16), .MAX_STALL(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pcwrite_i       (pcwrite),
        .ifid_write_i    (ifid_write),
        .ifid_flush_i    (ifid_flush),
        .branch_i        (branch),
        .branch_target_i (branch_target),
        .imem_instr_i    (imem_instr),
        .pc_o            (pc),
        .ifid_pc4_o      (ifid_pc4),
        .ifid_instr_o    (ifid_instr),
        .ifid_valid_o    (ifid_valid),
        .fetch_state_o   (fetch_state),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt),
        .stall_err_o     (stall_err)
    );

    ifid_fetch_stage #(.RESET_PC(32'h0), .CNT_W(4), .MAX_STALL(8)) dut_small (
        .clk_i           (clk),
        .rst_i           (rst),
        .pcwrite_i       (1'b1),
        .ifid_write_i    (1'b1),
        .ifid_flush_i    (s_flush),
        .branch_i        (1'b0),
        .branch_target_i (32'h0),
        .imem_instr_i    (32'h0000_0013),
        .pc_o            (s_pc),
        .ifid_pc4_o      (s_ifid_pc4),
        .ifid_instr_o    (s_ifid_instr),
        .ifid_valid_o    (s_ifid_valid),
        .fetch_state_o   (s_fetch_state),
        .stall_cnt_o     (s_stall_cnt),
        .flush_cnt_o     (s_flush_cnt),
        .stall_err_o     (s_stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input snap_t v);
        return $sformatf("pc=%h pc4=%h ins=%h v=%b st=%0d sc=%0d fc=%0d err=%b",
                         v.pc, v.pc4, v.instr, v.valid, v.state, v.scnt, v.fcnt, v.err);
    endfunction

    function automatic snap_t sample();
        return {pc, ifid_pc4, ifid_instr, ifid_valid, fetch_state, stall_cnt, flush_cnt, stall_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic pw, input logic iw, input logic fl,
                         input logic br, input logic [31:0] tgt, input logic [31:0] im);
        rst           = r;
        pcwrite       = pw;
        ifid_write    = iw;
        ifid_flush    = fl;
        branch        = br;
        branch_target = tgt;
        imem_instr    = im;
    endtask

    task automatic push_exp();
        sb_q.push_back({e_pc, e_pc4, e_instr, e_valid, e_state, e_scnt, e_fcnt, e_err});
    endtask

    task automatic exp_reset();
        e_pc = 32'h0; e_pc4 = 32'h0; e_instr = 32'h0; e_valid = 1'b0;
        e_state = 2'd0; e_scnt = 16'd0; e_fcnt = 16'd0; e_err = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2001_0005);
        s_flush = 1'b0;
        exp_reset();
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL reset: got %s want %s", fmt(got), fmt(want));
        end else $display("txn reset: %s", fmt(got));
    endtask

    task automatic test_run();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2001_0005);
            e_pc4 = e_pc + 32'd4; e_pc = e_pc + 32'd4;
            e_instr = 32'h2001_0005; e_valid = 1'b1; e_state = 2'd0;
            push_exp();
            tick();
            got = sample(); want = sb_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_errors++; $display("FAIL run[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end else $display("txn run[%0d]: %s", i, fmt(got));
        end
    endtask

    task automatic test_load_use();
        // One-cycle hazard stall at pc=0x10: PC and IF/ID hold.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
        e_state = 2'd1; e_scnt = e_scnt + 16'd1;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL load_use_stall: got %s want %s", fmt(got), fmt(want));
        end else $display("txn load_use_stall: %s", fmt(got));
        // Release: back to RUN, PC advances to 0x14.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0013);
        e_pc4 = 32'h14; e_pc = 32'h14; e_instr = 32'h0000_0013; e_state = 2'd0;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL load_use_release: got %s want %s", fmt(got), fmt(want));
        end else $display("txn load_use_release: %s", fmt(got));
    endtask

    task automatic test_branch_flush();
        // Branch plus flush: unaligned target, bubble, REDIRECT, one flush count.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0043, 32'hFFFF_FFFF);
        e_pc = 32'h40; e_pc4 = 32'h0; e_instr = 32'h0; e_valid = 1'b0;
        e_state = 2'd2; e_fcnt = e_fcnt + 16'd1;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL branch_flush: got %s want %s", fmt(got), fmt(want));
        end else $display("txn branch_flush: %s", fmt(got));
        // Target word reaches IF/ID on the second edge after the branch.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h00A0_0093);
        e_pc4 = 32'h44; e_pc = 32'h44; e_instr = 32'h00A0_0093; e_valid = 1'b1; e_state = 2'd0;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL branch_target_fetch: got %s want %s", fmt(got), fmt(want));
        end else $display("txn branch_target_fetch: %s", fmt(got));
        // Branch overrides pcwrite=0 and is not a stall.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_1234);
        e_pc = 32'h100; e_state = 2'd2;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL branch_no_pcwrite: got %s want %s", fmt(got), fmt(want));
        end else $display("txn branch_no_pcwrite: %s", fmt(got));
        // Stall straight after a redirect.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_5678);
        e_state = 2'd1; e_scnt = e_scnt + 16'd1;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL redirect_to_stall: got %s want %s", fmt(got), fmt(want));
        end else $display("txn redirect_to_stall: %s", fmt(got));
        // IF/ID loads while PC holds: pc4 is pc+4 of the held PC.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0040_0113);
        e_pc4 = 32'h104; e_instr = 32'h0040_0113; e_valid = 1'b1;
        e_state = 2'd1; e_scnt = e_scnt + 16'd1;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL write_only: got %s want %s", fmt(got), fmt(want));
        end else $display("txn write_only: %s", fmt(got));
        // Resume.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0013);
        e_pc = 32'h104; e_pc4 = 32'h104; e_instr = 32'h0000_0013; e_state = 2'd0;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL resume: got %s want %s", fmt(got), fmt(want));
        end else $display("txn resume: %s", fmt(got));
    endtask

    task automatic test_stall_watchdog();
        // Eight stalls are tolerated; a RUN cycle restarts the consecutive count.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
            e_state = 2'd1; e_scnt = e_scnt + 16'd1;
            push_exp();
            tick();
            got = sample(); want = sb_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_errors++; $display("FAIL stall8[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end else $display("txn stall8[%0d]: %s", i, fmt(got));
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0013);
        e_pc4 = e_pc + 32'd4; e_pc = e_pc + 32'd4; e_state = 2'd0;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL stall_gap: got %s want %s", fmt(got), fmt(want));
        end else $display("txn stall_gap: %s", fmt(got));
        // Nine consecutive stalls: error rises on the ninth edge.
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
            e_state = 2'd1; e_scnt = e_scnt + 16'd1; e_err = (i == 8);
            push_exp();
            tick();
            got = sample(); want = sb_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_errors++; $display("FAIL stall9[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end else $display("txn stall9[%0d]: %s", i, fmt(got));
        end
        // Error is sticky after the stall ends.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0013);
        e_pc4 = e_pc + 32'd4; e_pc = e_pc + 32'd4; e_state = 2'd0;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL err_sticky: got %s want %s", fmt(got), fmt(want));
        end else $display("txn err_sticky: %s", fmt(got));
        // Reset clears it.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0013);
        exp_reset();
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL err_cleared: got %s want %s", fmt(got), fmt(want));
        end else $display("txn err_cleared: %s", fmt(got));
    endtask

    task automatic test_wrap_saturate();
        // Branch to the top word, then advance: PC and pc4 both wrap to 0.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        e_pc = 32'hFFFF_FFFC; e_state = 2'd2;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL top_word: got %s want %s", fmt(got), fmt(want));
        end else $display("txn top_word: %s", fmt(got));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0033);
        e_pc = 32'h0; e_pc4 = 32'h0; e_instr = 32'h0000_0033; e_valid = 1'b1; e_state = 2'd0;
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL pc_wrap: got %s want %s", fmt(got), fmt(want));
        end else $display("txn pc_wrap: %s", fmt(got));
        // Twenty flushes into a 4-bit counter saturate at 4'hF.
        begin
            logic [3:0] s_exp_q[$];
            logic [3:0] s_want;
            for (int i = 0; i < 20; i++) begin
                s_flush = 1'b1;
                s_exp_q.push_back((i + 1 > 15) ? 4'hF : 4'(i + 1));
                tick();
                s_want = s_exp_q.pop_front(); n_checks++;
                if (s_flush_cnt !== s_want) begin
                    n_errors++; $display("FAIL flush_sat[%0d]: got %h want %h", i, s_flush_cnt, s_want);
                end else $display("txn flush_sat[%0d]: cnt=%h", i, s_flush_cnt);
            end
            s_flush = 1'b0;
            tick();
            n_checks++;
            if (s_flush_cnt !== 4'hF || s_ifid_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL flush_sat_hold: got cnt=%h v=%b want cnt=f v=1", s_flush_cnt, s_ifid_valid);
            end else $display("txn flush_sat_hold: cnt=%h", s_flush_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        n_checks++;
        if (fetch_state !== 2'd1) begin
            n_errors++; $display("FAIL pre_reset_stall: got st=%0d want st=1", fetch_state);
        end else $display("txn pre_reset_stall: st=%0d", fetch_state);
        // Reset wins over branch, flush and stall in the same cycle.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
        exp_reset();
        push_exp();
        tick();
        got = sample(); want = sb_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_errors++; $display("FAIL reset_mid_stall: got %s want %s", fmt(got), fmt(want));
        end else $display("txn reset_mid_stall: %s", fmt(got));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        s_flush = 1'b0;
        exp_reset();
        test_reset();
        test_run();
        test_load_use();
        test_branch_flush();
        test_stall_watchdog();
        test_wrap_saturate();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
